// File: rtl/draw_scheduler.sv
// Round-robin rectangle rasteriser and full-screen clear sequencer driving the VGA pixel port.
// Optional build macro DRAW_SCHED_CLIP_EN suppresses vga_plot for off-screen rectangle pixels.
module draw_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] rect_x,
  input  logic [7*NUM_REQ-1:0] rect_y,
  input  logic [4*NUM_REQ-1:0] rect_w_m1,
  input  logic [4*NUM_REQ-1:0] rect_h_m1,
  input  logic [3*NUM_REQ-1:0] rect_colour,
  input  logic                 clear_req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 clear_ack,
  output logic                 done,
  output logic                 busy,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [7:0]    x0;
  logic [6:0]    y0;
  logic [3:0]    w_m1, h_m1, ox, oy;
  logic [2:0]    colour;
  logic [7:0]    cx;
  logic [6:0]    cy;

  logic          any_req;
  logic [PW-1:0] sel, cand, next_ptr;
  int unsigned   cand_i;

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    cand    = '0;
    cand_i  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_i = (32'(rr_ptr) + k) % NUM_REQ;
      cand   = PW'(cand_i);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
    next_ptr = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  end

  logic [7:0] px;
  logic [6:0] py;
  logic       plot_en;

`ifdef DRAW_SCHED_CLIP_EN
  logic [8:0] px_full;
  logic [7:0] py_full;
  always_comb begin
    px_full = {1'b0, x0} + {5'b0, ox};
    py_full = {1'b0, y0} + {4'b0, oy};
    px      = px_full[7:0];
    py      = py_full[6:0];
    plot_en = (px_full < 9'(SCREEN_W)) && (py_full < 8'(SCREEN_H));
  end
`else
  always_comb begin
    px      = x0 + {4'b0, ox};
    py      = y0 + {3'b0, oy};
    plot_en = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      clear_ack  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      w_m1       <= '0;
      h_m1       <= '0;
      colour     <= '0;
      ox         <= '0;
      oy         <= '0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      grant     <= '0;
      clear_ack <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      vga_plot  <= 1'b0;
      case (state)
        IDLE: begin
          // busy still reflects the final pixel of the operation just finished.
          done <= busy;
          if (clear_req) begin
            clear_ack <= 1'b1;
            cx        <= '0;
            cy        <= '0;
            state     <= CLEAR;
          end else if (any_req) begin
            grant  <= NUM_REQ'(1) << sel;
            x0     <= rect_x[8*sel +: 8];
            y0     <= rect_y[7*sel +: 7];
            w_m1   <= rect_w_m1[4*sel +: 4];
            h_m1   <= rect_h_m1[4*sel +: 4];
            colour <= rect_colour[3*sel +: 3];
            ox     <= '0;
            oy     <= '0;
            rr_ptr <= next_ptr;
            state  <= DRAW;
          end
        end
        DRAW: begin
          busy       <= 1'b1;
          vga_plot   <= plot_en;
          vga_x      <= px;
          vga_y      <= py;
          vga_colour <= colour;
          if (ox == w_m1) begin
            ox <= '0;
            if (oy == h_m1) state <= IDLE;
            else            oy    <= oy + 1'b1;
          end else begin
            ox <= ox + 1'b1;
          end
        end
        CLEAR: begin
          busy       <= 1'b1;
          vga_plot   <= 1'b1;
          vga_x      <= cx;
          vga_y      <= cy;
          vga_colour <= '0;
          if (cx == 8'(SCREEN_W - 1)) begin
            cx <= '0;
            if (cy == 7'(SCREEN_H - 1)) state <= IDLE;
            else                        cy    <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Sequencing and arbitration controller for the single VGA pixel-write port of the 160x120, 3-bit-colour display. Game-object FSMs (ship, enemies, bullets, score) raise rectangle draw requests; the block grants one at a time round-robin, rasterises the granted rectangle one pixel per clock onto the plot/x/y/colour outputs, and runs a full-screen clear (black sweep) when asked. It sits between the object controllers and the VGA adapter, and is the only driver of the adapter's plot input.

## Interface
Parameters:
- NUM_REQ, 4, number of rectangle requesters (2..8)
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- resetn  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester draw request; level, held until granted
- rect_x  in  8*NUM_REQ  top-left x per requester, slice i = [8i+7:8i]
- rect_y  in  7*NUM_REQ  top-left y per requester
- rect_w_m1  in  4*NUM_REQ  width minus one (1..16 pixels)
- rect_h_m1  in  4*NUM_REQ  height minus one (1..16 pixels)
- rect_colour  in  3*NUM_REQ  fill colour per requester
- clear_req  in  1  request full-screen black sweep; level, held until clear_ack
- grant  out  NUM_REQ  one-hot, one-cycle pulse: request i accepted, inputs latched
- clear_ack  out  1  one-cycle pulse: clear accepted
- done  out  1  one-cycle pulse after last pixel of a rectangle or clear
- busy  out  1  high in DRAW or CLEAR
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write-enable to VGA adapter

## Operation
- States: IDLE, DRAW, CLEAR.
- IDLE: if clear_req, pulse clear_ack, zero sweep counters, go CLEAR. Else if any req, pick first asserted index at or after rr_ptr (wrapping), pulse its grant, latch its x/y/w_m1/h_m1/colour, zero offset counters, go DRAW, set rr_ptr = granted+1 mod NUM_REQ. Else stay.
- clear_req has priority over req in IDLE only; never pre-empts DRAW.
- DRAW: each cycle output pixel (x0+ox, y0+oy), colour latched; ox increments 0..w_m1, then ox=0, oy++. After ox==w_m1 && oy==h_m1, go IDLE. Row-major, x inner.
- CLEAR: each cycle output (cx, cy), colour 0; cx inner 0..SCREEN_W-1, cy outer 0..SCREEN_H-1; after (159,119) go IDLE.
- Arithmetic: x0+ox computed 9 bits, y0+oy computed 8 bits before clip check; outputs truncated to 8/7 bits.
- done pulses in the first IDLE cycle after DRAW or CLEAR; arbitration also runs in that cycle.
- Requests arriving during DRAW/CLEAR wait; req inputs of ungranted requesters are ignored until IDLE.
- Reset mid-operation: abort, state IDLE, no done pulse, rr_ptr = 0.

## Timing
- Reset values: grant=0, clear_ack=0, done=0, busy=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, rr_ptr=0, state IDLE.
- All outputs registered.
- Grant at cycle T (IDLE); first pixel (vga_plot=1) at T+1; w*h pixel cycles T+1..T+w*h; done at T+w*h+1; next grant possible at T+w*h+1 (one-cycle gap between back-to-back rectangles).
- Clear: ack at T, pixels T+1..T+19200, done at T+19201.
- busy high exactly during pixel cycles.
- grant and clear_ack never assert in the same cycle.

## Configuration
- DRAW_SCHED_CLIP_EN defined: pixels with 9-bit x >= SCREEN_W or 8-bit y >= SCREEN_H still consume their cycle but drive vga_plot=0 (x/y/colour still update).
- Not defined: no clip check; vga_plot=1 on every DRAW cycle with truncated coordinates (wrap-around on screen).

## Test plan
- Single req[0], x=10, y=20, w_m1=1, h_m1=1, colour=3'b100 -> grant=4'b0001 at T; plot at (10,20),(11,20),(10,21),(11,21) on T+1..T+4, colour 4; done at T+5.
- req=4'b1011 held continuously, 1x1 rectangles -> grants in order 0,1,3,0,1,3; each grant 2 cycles apart.
- clear_req and req[2] asserted together in IDLE -> clear_ack first, 19200 plot cycles colour 0 ending at (159,119), done, then grant[2] in that done cycle.
- With DRAW_SCHED_CLIP_EN: x=158, y=118, w_m1=3, h_m1=3 -> 16 pixel cycles, plot=1 only for x in {158,159}, y in {118,119} (4 pixels); without macro all 16 plotted, x wraps 158,159,160->160 trunc, y 118..121.
- resetn low during pixel 3 of a 4x4 draw -> next cycle all outputs at reset values, no done; re-request granted at rr_ptr=0 order.
- clear_req asserted mid-DRAW -> DRAW completes all pixels, done, clear_ack in same cycle as done.
